// File: rtl/al_npc_redirect.sv
// rtl/al_npc_redirect.sv - commit-side next-PC recovery sequencer: stall, flush, then redirect fetch.
// Optional RECOVERY_STATS_EN adds saturating mispredict/exception recovery counters.
module al_npc_redirect #(
  parameter int               DEPTH        = 16,
  parameter int               INDEX        = 4,
  parameter int               WIDTH        = 32,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INDEX-1:0] headIdx_i,
  input  logic             headValid_i,
  input  logic             headMispredict_i,
  input  logic             headException_i,
  output logic [INDEX-1:0] alNpcAddr_o,
  input  logic [WIDTH-1:0] alNpcData_i,
  output logic             commitStall_o,
  output logic             flush_o,
  output logic             redirectValid_o,
  input  logic             redirectReady_i,
  output logic [WIDTH-1:0] redirectPc_o,
  output logic             busy_o
`ifdef RECOVERY_STATS_EN
  ,
  output logic [15:0]      mispredCount_o,
  output logic [15:0]      excCount_o
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("al_npc_redirect: FLUSH_CYCLES must be in 1..15");
  end
  if (DEPTH != (1 << INDEX)) begin : g_bad_depth
    $error("al_npc_redirect: DEPTH must equal 2**INDEX");
  end

  state_t           state, next_state;
  logic [3:0]       count, next_count;
  logic [WIDTH-1:0] pc_reg, next_pc;
  logic             trigger;

  assign trigger      = headValid_i & (headMispredict_i | headException_i);
  assign alNpcAddr_o  = headIdx_i;
  assign redirectPc_o = pc_reg;
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      pc_reg <= '0;
    end else begin
      state  <= next_state;
      count  <= next_count;
      pc_reg <= next_pc;
    end
  end

  // Head inputs are only looked at in IDLE; once flushing they are stale.
  always_comb begin
    next_state      = state;
    next_count      = count;
    next_pc         = pc_reg;
    commitStall_o   = 1'b1;
    flush_o         = 1'b0;
    redirectValid_o = 1'b0;
    case (state)
      IDLE: begin
        commitStall_o = trigger;
        if (trigger) begin
          next_pc    = headException_i ? EXC_VECTOR : alNpcData_i;
          next_count = FLUSH_LOAD;
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        flush_o    = 1'b1;
        next_count = count - 4'd1;
        if (count == 4'd1) begin
          next_state = REDIRECT;
        end
      end
      REDIRECT: begin
        redirectValid_o = 1'b1;
        if (redirectReady_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef RECOVERY_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredCount_o <= 16'd0;
      excCount_o     <= 16'd0;
    end else if (state == IDLE && trigger) begin
      if (headException_i) begin
        if (excCount_o != 16'hFFFF) excCount_o <= excCount_o + 16'd1;
      end else begin
        if (mispredCount_o != 16'hFFFF) mispredCount_o <= mispredCount_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_al_npc_redirect.sv
// tb/tb_al_npc_redirect.sv - self-checking bench for al_npc_redirect (directed + random vs model).
module tb_al_npc_redirect;

  localparam int          F   = 2;
  localparam logic [31:0] EXC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  headIdx_i = 4'd0;
  logic        headValid_i = 1'b0;
  logic        headMispredict_i = 1'b0;
  logic        headException_i = 1'b0;
  logic [3:0]  alNpcAddr_o;
  logic [31:0] alNpcData_i = 32'd0;
  logic        commitStall_o;
  logic        flush_o;
  logic        redirectValid_o;
  logic        redirectReady_i = 1'b0;
  logic [31:0] redirectPc_o;
  logic        busy_o;
`ifdef RECOVERY_STATS_EN
  logic [15:0] mispredCount_o;
  logic [15:0] excCount_o;
`endif

  al_npc_redirect #(
    .DEPTH(16), .INDEX(4), .WIDTH(32), .FLUSH_CYCLES(F), .EXC_VECTOR(EXC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .headIdx_i(headIdx_i),
    .headValid_i(headValid_i),
    .headMispredict_i(headMispredict_i),
    .headException_i(headException_i),
    .alNpcAddr_o(alNpcAddr_o),
    .alNpcData_i(alNpcData_i),
    .commitStall_o(commitStall_o),
    .flush_o(flush_o),
    .redirectValid_o(redirectValid_o),
    .redirectReady_i(redirectReady_i),
    .redirectPc_o(redirectPc_o),
    .busy_o(busy_o)
`ifdef RECOVERY_STATS_EN
    ,
    .mispredCount_o(mispredCount_o),
    .excCount_o(excCount_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: a recovery is a run of F flush cycles followed by an offer
  // that persists until accepted; nothing new starts while one is pending.
  int          m_flush_left = 0;
  bit          m_redir = 0;
  logic [31:0] m_pc = 32'd0;
  int          m_mis = 0;
  int          m_exc = 0;

  always @(negedge clk) begin
    bit trig;
    bit mbusy;
    if (reset) begin
      m_flush_left = 0;
      m_redir      = 0;
      m_pc         = 32'd0;
      m_mis        = 0;
      m_exc        = 0;
    end
    mbusy = (m_flush_left > 0) || m_redir;
    trig  = headValid_i && (headMispredict_i || headException_i);
    chk("model_busy", busy_o, mbusy);
    chk("model_flush", flush_o, m_flush_left > 0);
    chk("model_valid", redirectValid_o, m_redir);
    chk("model_stall", commitStall_o, mbusy || trig);
    chk("model_addr", alNpcAddr_o, headIdx_i);
    if (m_redir || reset) chk("model_pc", redirectPc_o, m_pc);
`ifdef RECOVERY_STATS_EN
    chk("model_mis_cnt", mispredCount_o, m_mis);
    chk("model_exc_cnt", excCount_o, m_exc);
`endif
    if (!reset) begin
      if (!mbusy) begin
        if (trig) begin
          m_flush_left = F;
          m_pc = headException_i ? EXC : alNpcData_i;
          if (headException_i) begin
            if (m_exc < 65535) m_exc++;
          end else begin
            if (m_mis < 65535) m_mis++;
          end
        end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) m_redir = 1;
      end else if (redirectReady_i) begin
        m_redir = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input logic v, input logic m, input logic e,
                      input logic [3:0] idx, input logic [31:0] d);
    headValid_i      = v;
    headMispredict_i = m;
    headException_i  = e;
    headIdx_i        = idx;
    alNpcData_i      = d;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_valid", redirectValid_o, 1'b0);
    chk("rst_pc", redirectPc_o, 32'd0);
    chk("rst_stall", commitStall_o, 1'b0);
    reset = 1'b0;

    // Mispredict at idx 5, ready already high
    redirectReady_i = 1'b1;
    head(1, 1, 0, 4'd5, 32'h0000_4000);
    #1;
    chk("t1_stall", commitStall_o, 1'b1);
    chk("t1_addr", alNpcAddr_o, 4'd5);
    chk("t1_noflush", flush_o, 1'b0);
    cyc(); head(0, 0, 0, 4'd0, 32'd0); #1;
    chk("t1_flush1", flush_o, 1'b1);
    chk("t1_busy", busy_o, 1'b1);
    cyc(); #1;
    chk("t1_flush2", flush_o, 1'b1);
    cyc(); #1;
    chk("t1_flush_end", flush_o, 1'b0);
    chk("t1_valid", redirectValid_o, 1'b1);
    chk("t1_pc", redirectPc_o, 32'h0000_4000);
    cyc(); #1;
    chk("t1_idle_valid", redirectValid_o, 1'b0);
    chk("t1_idle_busy", busy_o, 1'b0);
`ifdef RECOVERY_STATS_EN
    chk("t1_mis_cnt", mispredCount_o, 16'd1);
    chk("t1_exc_cnt", excCount_o, 16'd0);
`endif

    // Exception + mispredict: exception wins
    head(1, 1, 1, 4'd3, 32'h0000_1234);
    cyc(); head(0, 0, 0, 4'd0, 32'd0); #1;
`ifdef RECOVERY_STATS_EN
    chk("t2_exc_cnt", excCount_o, 16'd1);
    chk("t2_mis_cnt", mispredCount_o, 16'd1);
`endif
    cyc(); cyc(); #1;
    chk("t2_valid", redirectValid_o, 1'b1);
    chk("t2_pc", redirectPc_o, 32'h0000_0080);
    cyc();

    // Ready held low while head inputs toggle
    redirectReady_i = 1'b0;
    head(1, 1, 0, 4'd7, 32'h0000_0500);
    cyc(); head(0, 0, 0, 4'd0, 32'd0);
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      head((i % 2) == 1, 1'b1, i >= 2, 4'(i), 32'h0000_DEAD);
      #1;
      chk("t3_hold_valid", redirectValid_o, 1'b1);
      chk("t3_hold_pc", redirectPc_o, 32'h0000_0500);
      cyc();
    end
    head(0, 0, 0, 4'd0, 32'd0);
    redirectReady_i = 1'b1;
    #1;
    chk("t3_accept_pc", redirectPc_o, 32'h0000_0500);
    cyc(); #1;
    chk("t3_after_busy", busy_o, 1'b0);
    chk("t3_after_valid", redirectValid_o, 1'b0);
    cyc(); #1;
    chk("t3_no_retrigger", busy_o, 1'b0);

    // Asynchronous reset while counter==1 in FLUSH
    head(1, 1, 0, 4'd2, 32'h0000_0900);
    cyc(); head(0, 0, 0, 4'd0, 32'd0);
    cyc(); #1;
    chk("t4_flush_pre", flush_o, 1'b1);
    reset = 1'b1;
    #1;
    chk("t4_async_flush", flush_o, 1'b0);
    chk("t4_async_stall", commitStall_o, 1'b0);
    chk("t4_async_busy", busy_o, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t4_no_redirect", redirectValid_o, 1'b0);
      chk("t4_idle", busy_o, 1'b0);
    end
`ifdef RECOVERY_STATS_EN
    chk("t4_cnt_cleared", mispredCount_o, 16'd0);
`endif

    // Back-to-back recoveries, idx 15 then 0
    redirectReady_i = 1'b1;
    head(1, 1, 0, 4'd15, 32'h0000_0100);
    #1;
    chk("t5_addr15", alNpcAddr_o, 4'd15);
    cyc(); head(0, 0, 0, 4'd0, 32'd0);
    cyc(); cyc(); #1;
    chk("t5_pc1", redirectPc_o, 32'h0000_0100);
    chk("t5_valid1", redirectValid_o, 1'b1);
    head(1, 1, 0, 4'd0, 32'h0000_0200);
    cyc(); #1;
    chk("t5_gap_busy", busy_o, 1'b0);
    chk("t5_gap_stall", commitStall_o, 1'b1);
    chk("t5_addr0", alNpcAddr_o, 4'd0);
    cyc(); head(0, 0, 0, 4'd0, 32'd0); #1;
    chk("t5_flush2", flush_o, 1'b1);
    cyc(); cyc(); #1;
    chk("t5_valid2", redirectValid_o, 1'b1);
    chk("t5_pc2", redirectPc_o, 32'h0000_0200);
    cyc(); #1;
    chk("t5_done", busy_o, 1'b0);

    // Mispredict flag without valid head
    head(0, 1, 0, 4'd9, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_stall", commitStall_o, 1'b0);
      chk("t6_flush", flush_o, 1'b0);
      chk("t6_busy", busy_o, 1'b0);
      cyc();
    end
    head(0, 0, 0, 4'd0, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        head(0, 0, 0, 4'($urandom), 32'd0);
      end else begin
        reset = 1'b0;
        head($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, 4'($urandom), $urandom);
      end
      redirectReady_i = $urandom_range(0, 2) != 0;
    end
    reset = 1'b0;
    head(0, 0, 0, 4'd0, 32'd0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
